text_cursor_writer: RTL and testbench

- Upstream feeder of the character display RAM: consumes a byte stream (UART RX side) and turns it into RAM write commands (we, w_row, w_col, din, langin).
- Tracks a terminal-style cursor and decodes Thai UTF-8 (U+0E00–U+0E7F) into 9-bit glyph codes with the Thai flag set.
- Handles CR, LF, BS and FF control codes, plus line wrap.
- On LF, wrap and FF it clears rows with a multi-cycle fill state, back-pressuring the source while it does so.

---
 rtl/text_pkg.sv | 13 +
 rtl/thai_utf8_decoder.sv | 65 ++++++
 rtl/text_cursor_writer.sv | 140 ++++++++++++++
 tb/tb_text_cursor_writer.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/text_pkg.sv
// Shared constants and state encoding for the text cursor writer and its Thai UTF-8 decoder.
package text_pkg;
    localparam logic [7:0] ASCII_CR   = 8'h0D;
    localparam logic [7:0] ASCII_LF   = 8'h0A;
    localparam logic [7:0] ASCII_BS   = 8'h08;
    localparam logic [7:0] ASCII_FF   = 8'h0C;
    localparam logic [7:0] UTF_LEAD   = 8'hE0;
    localparam logic [7:0] THAI_B2_LO = 8'hB8;
    localparam logic [7:0] THAI_B2_HI = 8'hB9;
    localparam logic [8:0] THAI_FLAG  = 9'h100;

    typedef enum logic [1:0] {IDLE, UTF_B2, UTF_B3, CLEAR} state_t;
endpackage

// File: rtl/thai_utf8_decoder.sv
// Byte sequencer for Thai UTF-8 (E0 B8/B9 xx); claims every byte >= 0x80 and every byte mid-sequence.
module thai_utf8_decoder
    import text_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       byte_valid,
    input  logic [7:0] byte_data,
    output logic       consumed,
    output logic       glyph_valid,
    output logic [8:0] glyph,
    output logic       lang,
    output logic       err
);
    state_t state;
    logic   hi;

    always_comb begin
        consumed    = 1'b0;
        glyph_valid = 1'b0;
        glyph       = 9'h000;
        lang        = 1'b0;
        err         = 1'b0;
        if (byte_valid) begin
            case (state)
                IDLE: begin
                    consumed = byte_data[7];
                    err      = byte_data[7] && (byte_data != UTF_LEAD);
                end
                UTF_B2: begin
                    consumed = 1'b1;
                    err      = (byte_data != THAI_B2_LO) && (byte_data != THAI_B2_HI);
                end
                UTF_B3: begin
                    consumed = 1'b1;
                    if (byte_data[7:6] == 2'b10) begin
                        glyph_valid = 1'b1;
                        glyph       = THAI_FLAG | {2'b00, hi, byte_data[5:0]};
                        lang        = 1'b1;
                    end else begin
                        err = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else if (byte_valid) begin
            case (state)
                IDLE:    if (byte_data == UTF_LEAD) state <= UTF_B2;
                UTF_B2:  state <= ((byte_data == THAI_B2_LO) || (byte_data == THAI_B2_HI)) ? UTF_B3 : IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Only meaningful while in UTF_B3, so it needs no reset.
    always_ff @(posedge clk) begin
        if (byte_valid && (state == UTF_B2)) hi <= (byte_data == THAI_B2_HI);
    end
endmodule

// File: rtl/text_cursor_writer.sv
// Terminal-style cursor that turns a byte stream into character-RAM writes, with row/screen clearing.
module text_cursor_writer
    import text_pkg::*;
#(
    parameter int DATA_WIDTH = 9,
    parameter int ROWS       = 4,
    parameter int COLS       = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    input  logic [7:0]              in_data,
    output logic                    in_ready,
    output logic                    we,
    output logic [$clog2(ROWS)-1:0] w_row,
    output logic [$clog2(COLS)-1:0] w_col,
    output logic [DATA_WIDTH-1:0]   din,
    output logic                    langin,
    output logic [$clog2(ROWS)-1:0] cur_row,
    output logic [$clog2(COLS)-1:0] cur_col,
    output logic                    utf_err
);
    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);
    localparam int NW = $clog2(ROWS * COLS) + 1;

    state_t              state;
    logic [NW-1:0]       clr_cnt;
    logic [NW-1:0]       clr_end;
    logic                accept;
    logic                consumed;
    logic                glyph_valid;
    logic [8:0]          glyph;
    logic                lang;
    logic                err;
    logic                char_valid;
    logic [DATA_WIDTH-1:0] char_code;
    logic [RW-1:0]       next_row;
    logic [NW-1:0]       row_base;

    assign in_ready = (state != CLEAR);
    assign accept   = in_valid && in_ready;

    thai_utf8_decoder u_dec (
        .clk         (clk),
        .reset       (reset),
        .byte_valid  (accept),
        .byte_data   (in_data),
        .consumed    (consumed),
        .glyph_valid (glyph_valid),
        .glyph       (glyph),
        .lang        (lang),
        .err         (err)
    );

    assign char_valid = glyph_valid ||
                        (accept && !consumed && (in_data >= 8'h20) && (in_data <= 8'h7E));
    assign char_code  = glyph_valid ? DATA_WIDTH'(glyph) : DATA_WIDTH'({1'b0, in_data});
    assign next_row   = (cur_row == RW'(ROWS - 1)) ? '0 : cur_row + 1'b1;
    // Clear counter is a linear cell index; COLS is a power of two so row/col are bit slices.
    assign row_base   = NW'({next_row, {CW{1'b0}}});

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cur_row <= '0;
            cur_col <= '0;
            we      <= 1'b0;
            w_row   <= '0;
            w_col   <= '0;
            din     <= '0;
            langin  <= 1'b0;
            utf_err <= 1'b0;
            clr_cnt <= '0;
            clr_end <= '0;
        end else begin
            we      <= 1'b0;
            utf_err <= 1'b0;
            if (state == CLEAR) begin
                if (clr_cnt == clr_end) begin
                    state <= IDLE;
                end else begin
                    we      <= 1'b1;
                    w_row   <= clr_cnt[CW +: RW];
                    w_col   <= clr_cnt[CW-1:0];
                    din     <= '0;
                    langin  <= 1'b0;
                    clr_cnt <= clr_cnt + 1'b1;
                end
            end else if (accept) begin
                utf_err <= err;
                if (char_valid) begin
                    we     <= 1'b1;
                    w_row  <= cur_row;
                    w_col  <= cur_col;
                    din    <= char_code;
                    langin <= lang;
                    if (cur_col == CW'(COLS - 1)) begin
                        cur_col <= '0;
                        cur_row <= next_row;
                        state   <= CLEAR;
                        clr_cnt <= row_base;
                        clr_end <= row_base + NW'(COLS);
                    end else begin
                        cur_col <= cur_col + 1'b1;
                    end
                end else if (!consumed) begin
                    case (in_data)
                        ASCII_CR: cur_col <= '0;
                        ASCII_LF: begin
                            cur_col <= '0;
                            cur_row <= next_row;
                            state   <= CLEAR;
                            clr_cnt <= row_base;
                            clr_end <= row_base + NW'(COLS);
                        end
                        ASCII_BS: begin
                            if (cur_col != '0) begin
                                cur_col <= cur_col - 1'b1;
                                we      <= 1'b1;
                                w_row   <= cur_row;
                                w_col   <= cur_col - 1'b1;
                                din     <= '0;
                                langin  <= 1'b0;
                            end
                        end
                        ASCII_FF: begin
                            cur_row <= '0;
                            cur_col <= '0;
                            state   <= CLEAR;
                            clr_cnt <= '0;
                            clr_end <= NW'(ROWS * COLS);
                        end
                        default: ;
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_text_cursor_writer.sv
// Directed bench for text_cursor_writer: ASCII, Thai UTF-8, wrap/LF/CR/BS/FF clears and reset aborts.
module tb_text_cursor_writer;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready;
    logic       we;
    logic [1:0] w_row;
    logic [4:0] w_col;
    logic [8:0] din;
    logic       langin;
    logic [1:0] cur_row;
    logic [4:0] cur_col;
    logic       utf_err;

    int vectors = 0;
    int miscompares = 0;

    text_cursor_writer #(.DATA_WIDTH(9), .ROWS(4), .COLS(32)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .we(we), .w_row(w_row), .w_col(w_col), .din(din),
        .langin(langin), .cur_row(cur_row), .cur_col(cur_col), .utf_err(utf_err)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Present one byte for one cycle; returns 1 time unit after the accepting edge.
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Step cycles until in_ready returns, counting clear writes seen on the way.
    task automatic wait_idle(input int budget, output int nwrites, output bit timed_out);
        nwrites   = 0;
        timed_out = 1'b1;
        for (int i = 0; i < budget; i++) begin
            if (in_ready) begin
                timed_out = 1'b0;
                break;
            end
            if (we) nwrites++;
            #10;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (we !== 1'b0 || utf_err !== 1'b0 || din !== 9'h000) begin
            miscompares++;
            $display("FAIL reset_outputs: we=%b utf_err=%b din=%h, want 0 0 000", we, utf_err, din);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        vectors++;
        if (in_ready !== 1'b1 || cur_row !== 2'd0 || cur_col !== 5'd0) begin
            miscompares++;
            $display("FAIL reset_release: in_ready=%b cur=(%0d,%0d), want 1 (0,0)", in_ready, cur_row, cur_col);
        end
    endtask

    task automatic test_ascii();
        send_byte(8'h41);
        vectors++;
        if (we !== 1'b1 || w_row !== 2'd0 || w_col !== 5'd0 || din !== 9'h041 || langin !== 1'b0) begin
            miscompares++;
            $display("FAIL ascii_write: we=%b at (%0d,%0d) din=%h lang=%b, want 1 (0,0) 041 0",
                     we, w_row, w_col, din, langin);
        end
        vectors++;
        if (cur_row !== 2'd0 || cur_col !== 5'd1) begin
            miscompares++;
            $display("FAIL ascii_cursor: got (%0d,%0d) want (0,1)", cur_row, cur_col);
        end
        #10;
        vectors++;
        if (we !== 1'b0) begin
            miscompares++;
            $display("FAIL ascii_we_pulse: we=%b want 0", we);
        end
    endtask

    task automatic test_thai();
        logic [7:0] seq [6];
        seq = '{8'hE0, 8'hB8, 8'h81, 8'hE0, 8'hB9, 8'h80};
        for (int i = 0; i < 6; i++) begin
            send_byte(seq[i]);
            vectors++;
            if (utf_err !== 1'b0) begin
                miscompares++;
                $display("FAIL thai_no_err[%0d]: utf_err=%b want 0", i, utf_err);
            end
            if (i == 2) begin
                vectors++;
                if (we !== 1'b1 || w_col !== 5'd1 || din !== 9'h101 || langin !== 1'b1) begin
                    miscompares++;
                    $display("FAIL thai_ko_kai: we=%b col=%0d din=%h lang=%b, want 1 1 101 1", we, w_col, din, langin);
                end
            end else if (i == 5) begin
                vectors++;
                if (we !== 1'b1 || w_col !== 5'd2 || din !== 9'h140 || langin !== 1'b1) begin
                    miscompares++;
                    $display("FAIL thai_hi_page: we=%b col=%0d din=%h lang=%b, want 1 2 140 1", we, w_col, din, langin);
                end
            end else begin
                vectors++;
                if (we !== 1'b0) begin
                    miscompares++;
                    $display("FAIL thai_prefix_nowrite[%0d]: we=%b want 0", i, we);
                end
            end
        end
        vectors++;
        if (cur_row !== 2'd0 || cur_col !== 5'd3) begin
            miscompares++;
            $display("FAIL thai_cursor: got (%0d,%0d) want (0,3)", cur_row, cur_col);
        end
    endtask

    task automatic test_ff_and_wrap();
        int  n;
        bit  to;
        int  bad;
        send_byte(8'h0C);
        wait_idle(300, n, to);
        vectors++;
        if (to || n != 128) begin
            miscompares++;
            $display("FAIL ff_clear: writes=%0d timeout=%b, want 128 0", n, to);
        end
        vectors++;
        if (cur_row !== 2'd0 || cur_col !== 5'd0) begin
            miscompares++;
            $display("FAIL ff_cursor: got (%0d,%0d) want (0,0)", cur_row, cur_col);
        end
        bad = 0;
        for (int i = 0; i < 32; i++) begin
            send_byte(8'h78);
            if (we !== 1'b1 || w_row !== 2'd0 || w_col !== 5'(i) || din !== 9'h078) bad++;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL wrap_row_chars: %0d bad writes, want 0 (last at col %0d)", bad, w_col);
        end
        vectors++;
        if (in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL wrap_ready_char_cycle: in_ready=%b want 0", in_ready);
        end
        bad = 0;
        for (int j = 0; j < 32; j++) begin
            #10;
            if (we !== 1'b1 || w_row !== 2'd1 || w_col !== 5'(j) || din !== 9'h000 ||
                langin !== 1'b0 || in_ready !== 1'b0) bad++;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL wrap_clear_row1: %0d bad clear cycles, want 0", bad);
        end
        #10;
        vectors++;
        if (we !== 1'b0 || in_ready !== 1'b1 || cur_row !== 2'd1 || cur_col !== 5'd0) begin
            miscompares++;
            $display("FAIL wrap_end: we=%b ready=%b cur=(%0d,%0d), want 0 1 (1,0)", we, in_ready, cur_row, cur_col);
        end
    endtask

    task automatic test_lf_cr();
        int n;
        bit to;
        int bad;
        for (int k = 0; k < 2; k++) begin
            send_byte(8'h0A);
            wait_idle(100, n, to);
            vectors++;
            if (to || n != 32) begin
                miscompares++;
                $display("FAIL lf_clear[%0d]: writes=%0d timeout=%b, want 32 0", k, n, to);
            end
        end
        for (int i = 0; i < 5; i++) send_byte(8'h61);
        vectors++;
        if (cur_row !== 2'd3 || cur_col !== 5'd5) begin
            miscompares++;
            $display("FAIL lf_setup: cur=(%0d,%0d) want (3,5)", cur_row, cur_col);
        end
        send_byte(8'h0A);
        vectors++;
        if (we !== 1'b0 || in_ready !== 1'b0 || cur_row !== 2'd0 || cur_col !== 5'd0) begin
            miscompares++;
            $display("FAIL lf_rowwrap: we=%b ready=%b cur=(%0d,%0d), want 0 0 (0,0)", we, in_ready, cur_row, cur_col);
        end
        bad = 0;
        for (int j = 0; j < 32; j++) begin
            #10;
            if (we !== 1'b1 || w_row !== 2'd0 || w_col !== 5'(j) || din !== 9'h000) bad++;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL lf_clear_row0: %0d bad clear cycles, want 0", bad);
        end
        wait_idle(10, n, to);
        for (int k = 0; k < 2; k++) begin
            send_byte(8'h0A);
            wait_idle(100, n, to);
        end
        for (int i = 0; i < 7; i++) send_byte(8'h62);
        vectors++;
        if (cur_row !== 2'd2 || cur_col !== 5'd7) begin
            miscompares++;
            $display("FAIL cr_setup: cur=(%0d,%0d) want (2,7)", cur_row, cur_col);
        end
        send_byte(8'h0D);
        vectors++;
        if (we !== 1'b0 || cur_row !== 2'd2 || cur_col !== 5'd0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL cr: we=%b ready=%b cur=(%0d,%0d), want 0 1 (2,0)", we, in_ready, cur_row, cur_col);
        end
    endtask

    task automatic test_utf_err_bs();
        send_byte(8'hE0);
        send_byte(8'h41);
        vectors++;
        if (utf_err !== 1'b1 || we !== 1'b0) begin
            miscompares++;
            $display("FAIL utf_bad_b2: utf_err=%b we=%b, want 1 0", utf_err, we);
        end
        #10;
        vectors++;
        if (utf_err !== 1'b0 || cur_col !== 5'd0) begin
            miscompares++;
            $display("FAIL utf_err_pulse: utf_err=%b col=%0d, want 0 0", utf_err, cur_col);
        end
        send_byte(8'h08);
        vectors++;
        if (we !== 1'b0 || cur_row !== 2'd2 || cur_col !== 5'd0) begin
            miscompares++;
            $display("FAIL bs_col0: we=%b cur=(%0d,%0d), want 0 (2,0)", we, cur_row, cur_col);
        end
        send_byte(8'h43);
        vectors++;
        if (we !== 1'b1 || din !== 9'h043 || w_col !== 5'd0) begin
            miscompares++;
            $display("FAIL after_err_idle: we=%b din=%h col=%0d, want 1 043 0", we, din, w_col);
        end
        send_byte(8'h08);
        vectors++;
        if (we !== 1'b1 || w_row !== 2'd2 || w_col !== 5'd0 || din !== 9'h000 || cur_col !== 5'd0) begin
            miscompares++;
            $display("FAIL bs_erase: we=%b at (%0d,%0d) din=%h cur_col=%0d, want 1 (2,0) 000 0",
                     we, w_row, w_col, din, cur_col);
        end
        send_byte(8'h95);
        vectors++;
        if (utf_err !== 1'b1 || we !== 1'b0) begin
            miscompares++;
            $display("FAIL lone_high_byte: utf_err=%b we=%b, want 1 0", utf_err, we);
        end
        send_byte(8'hE0);
        send_byte(8'hB8);
        send_byte(8'hC0);
        vectors++;
        if (utf_err !== 1'b1 || we !== 1'b0) begin
            miscompares++;
            $display("FAIL bad_b3: utf_err=%b we=%b, want 1 0", utf_err, we);
        end
    endtask

    task automatic test_reset_mid_clear();
        send_byte(8'h0C);
        #100;
        vectors++;
        if (we !== 1'b1 || in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL ff_in_progress: we=%b ready=%b, want 1 0", we, in_ready);
        end
        #2;
        reset = 1'b1;
        #1;
        vectors++;
        if (we !== 1'b0 || cur_row !== 2'd0 || cur_col !== 5'd0) begin
            miscompares++;
            $display("FAIL async_reset_clear: we=%b cur=(%0d,%0d), want 0 (0,0)", we, cur_row, cur_col);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL ready_after_reset: in_ready=%b want 1", in_ready);
        end
        send_byte(8'h5A);
        vectors++;
        if (we !== 1'b1 || din !== 9'h05A || w_row !== 2'd0 || w_col !== 5'd0) begin
            miscompares++;
            $display("FAIL post_reset_char: we=%b din=%h at (%0d,%0d), want 1 05A (0,0)", we, din, w_row, w_col);
        end
        #10;
        vectors++;
        if (we !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL clear_aborted: we=%b ready=%b, want 0 1", we, in_ready);
        end
        send_byte(8'hE0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        send_byte(8'h51);
        vectors++;
        if (we !== 1'b1 || din !== 9'h051 || langin !== 1'b0 || utf_err !== 1'b0) begin
            miscompares++;
            $display("FAIL utf_aborted: we=%b din=%h lang=%b err=%b, want 1 051 0 0", we, din, langin, utf_err);
        end
    endtask

    initial begin
        test_reset();
        test_ascii();
        test_thai();
        test_ff_and_wrap();
        test_lf_cr();
        test_utf_err_bs();
        test_reset_mid_clear();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
